macc_chunk_scheduler: RTL and testbench

MACC_CHUNK_SCHEDULER -- requirements
Module: macc_chunk_scheduler

---
 rtl/macc_chunk_scheduler.sv | 150 +++++++++++++++
 tb/tb_macc_chunk_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/macc_chunk_scheduler.sv
// Feeds NUM_CHUNKS operand beats to an external MACC and sums the
// returned partial sums into one signed dot-product result.
module macc_chunk_scheduler #(
  parameter int NUM_INPUTS = 20,
  parameter int NUM_CHUNKS = 4,
  localparam int W_P   = 16 + $clog2(NUM_INPUTS),
  localparam int W_ACC = W_P + $clog2(NUM_CHUNKS),
  localparam int W_D   = 8 * NUM_INPUTS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  output logic                    o_busy,
  input  logic [W_D-1:0]          i_data_a,
  input  logic [W_D-1:0]          i_data_b,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [W_D-1:0]          o_macc_data_a,
  output logic [W_D-1:0]          o_macc_data_b,
  output logic                    o_macc_valid,
  input  logic [W_P-1:0]          i_macc_data,
  input  logic                    i_macc_valid,
  output logic signed [W_ACC-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_err
);

  localparam int CW = $clog2(NUM_CHUNKS + 1);
  localparam logic [CW-1:0] NC    = CW'(NUM_CHUNKS);
  localparam logic [CW-1:0] NC_M1 = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            beat_q, beat_d;
  logic [CW-1:0]            res_q, res_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic                     err_q, err_d;
  logic                     mv_q, mv_d;
  logic [W_D-1:0]           a_q, a_d;
  logic [W_D-1:0]           b_q, b_d;

  logic                     accept;
  logic                     take;
  logic signed [W_ACC-1:0]  ext;

  assign ext = W_ACC'($signed(i_macc_data));

  // Next-state, counters, accumulation and error detection
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    res_d   = res_q;
    acc_d   = acc_q;
    err_d   = err_q;
    mv_d    = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    accept  = (state_q == S_FEED) && i_valid;
    take    = i_macc_valid
              && ((state_q == S_FEED) || (state_q == S_WAIT))
              && (res_q != NC);

    if (i_macc_valid && !take) begin
      err_d = 1'b1;
    end

    if (accept) begin
      mv_d = 1'b1;
      a_d  = i_data_a;
      b_d  = i_data_b;
    end

    if (take) begin
      acc_d = acc_q + ext;
      res_d = res_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FEED;
          acc_d   = '0;
          beat_d  = '0;
          res_d   = '0;
        end
      end
      S_FEED: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == NC_M1) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if ((take && (res_q == NC_M1)) || (res_q == NC)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
    end
  end

  // Operand registers toward the MACC; contents are don't-care after reset
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_ready       = (state_q == S_FEED);
  assign o_valid       = (state_q == S_DONE);
  assign o_data        = acc_q;
  assign o_err         = err_q;
  assign o_macc_valid  = mv_q;
  assign o_macc_data_a = a_q;
  assign o_macc_data_b = b_q;

endmodule

// File: tb/tb_macc_chunk_scheduler.sv
// Directed bench for macc_chunk_scheduler with a latency-4 MACC model.
// Expected sums are hand-computed constants.
module tb_macc_chunk_scheduler;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_start = 1'b0;
  logic                o_busy;
  logic [159:0]        i_data_a = '0;
  logic [159:0]        i_data_b = '0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic [159:0]        o_macc_data_a;
  logic [159:0]        o_macc_data_b;
  logic                o_macc_valid;
  logic [20:0]         i_macc_data;
  logic                i_macc_valid;
  logic signed [22:0]  o_data;
  logic                o_valid;
  logic                i_ready = 1'b0;
  logic                o_err;

  logic                inj = 1'b0;
  logic [3:0]          pv = '0;
  logic [20:0]         pd [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  macc_chunk_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .i_data_a      (i_data_a),
    .i_data_b      (i_data_b),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_macc_data_a (o_macc_data_a),
    .o_macc_data_b (o_macc_data_b),
    .o_macc_valid  (o_macc_valid),
    .i_macc_data   (i_macc_data),
    .i_macc_valid  (i_macc_valid),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_err         (o_err)
  );

  function automatic logic [20:0] dot(input logic [159:0] a,
                                      input logic [159:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 20; k++) begin
      s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    end
    return 21'(s);
  endfunction

  // External MACC model: four-cycle latency, in-order
  always @(posedge clk) begin
    pv    <= {pv[2:0], o_macc_valid};
    pd[0] <= dot(o_macc_data_a, o_macc_data_b);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign i_macc_valid = pv[3] | inj;
  assign i_macc_data  = pd[3];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int a, input int da, input int b,
                     input bit tog, input longint exp,
                     input int hold);
    logic [7:0] av;
    logic [7:0] bv;
    bit         acc_now;
    int         beats;
    int         cyc;
    int         extra;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_feed", o_busy, 1);
    chk("ready_feed", o_ready, 1);
    beats = 0;
    cyc = 0;
    while (beats < 4 && cyc < 40) begin
      av = 8'(a + beats * da);
      bv = 8'(b);
      i_data_a = {20{av}};
      i_data_b = {20{bv}};
      i_valid = tog ? ((cyc % 2) == 0) : 1'b1;
      acc_now = o_ready && i_valid;
      step();
      cyc++;
      if (acc_now) begin
        beats++;
        chk("mv_beat", o_macc_valid, 1);
        chk("mda_hi", o_macc_data_a[159:152], av);
        chk("mdb_lo", o_macc_data_b[7:0], bv);
      end else if (tog) begin
        chk("mv_gap", o_macc_valid, 0);
      end
    end
    chk("beats", beats, 4);
    i_valid = tog;
    cyc = 0;
    extra = 0;
    while (!o_valid && cyc < 40) begin
      step();
      cyc++;
      if (o_macc_valid) extra++;
    end
    i_valid = 1'b0;
    chk("no_extra_mv", extra, 0);
    chk("done_timeout", o_valid, 1);
    chk("data", o_data, exp);
    for (int k = 0; k < hold; k++) begin
      i_ready = 1'b0;
      i_start = (k == 2);
      step();
      i_start = 1'b0;
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, exp);
      chk("hold_busy", o_busy, 1);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_valid, 0);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_mv", o_macc_valid, 0);
    step();

    run(1, 0, 1, 1'b0, 80, 0);
    run(-128, 0, -128, 1'b0, 1310720, 0);
    run(-128, 0, 127, 1'b0, -1300480, 5);
    run(1, 0, 1, 1'b1, 80, 0);
    run(1, 1, 1, 1'b0, 200, 0);
    chk("err_clean", o_err, 0);

    // reset in the middle of FEED, partials still in flight
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_data_a = {20{8'd3}};
    i_data_b = {20{8'd3}};
    i_valid = 1'b1;
    step();
    step();
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_mv", o_macc_valid, 0);
    chk("mid_rst_err", o_err, 0);
    repeat (8) step();
    chk("late_err", o_err, 1);
    run(2, 0, 3, 1'b0, 480, 0);
    chk("late_err_sticky", o_err, 1);

    // spurious partial sum in IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", o_err, 0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("idle_err", o_err, 1);
    run(1, 0, -1, 1'b0, -80, 0);
    chk("idle_err_sticky", o_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
